// File: rtl/shift_deser_rx.sv
// shift_deser_rx: framed serial-to-parallel receiver.
//
// Collects one bit per ser_en strobe after a start pulse. Bits are assembled
// MSB-first (dir=0, shift-left fill) or LSB-first (dir=1, shift-right fill).
// When PARITY_EN=1 an even-parity bit follows the data bits and is checked
// but not stored. Completed words land in a valid/ready holding register.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-low
//   start      : frame-start pulse (also aborts and restarts a frame in progress)
//   dir        : 0 = MSB first, 1 = LSB first; latched on start
//   ser_en     : bit strobe, honoured only while shifting
//   ser_in     : serial data bit
//   dout       : last accepted word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer handshake
//   busy       : frame in progress
//   overrun    : sticky, a completed word was dropped because dout was full
//   parity_err : sticky, a completed frame had a parity mismatch
//   clr_flags  : synchronous clear of overrun and parity_err
module shift_deser_rx #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned PARITY_EN = 0,
   parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic             ser_en,
   input  logic             ser_in,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err,
   input  logic             clr_flags
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             perr_q, perr_d;

   logic [WIDTH-1:0] shift_val;
   logic [WIDTH-1:0] word;
   logic             complete;
   logic             perr_hit;

   // Frame sequencing
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      dir_d    = dir_q;
      complete = 1'b0;
      word     = shreg_q;
      perr_hit = 1'b0;

      shift_val = dir_q ? {ser_in, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], ser_in};

      if (start) begin
         // Start always wins: aborts any partial frame without emitting it.
         state_d = ST_SHIFT;
         cnt_d   = '0;
         shreg_d = '0;
         dir_d   = dir;
      end else if (state_q == ST_SHIFT && ser_en) begin
         if (cnt_q < CNT_WIDTH) begin
            shreg_d = shift_val;
            cnt_d   = cnt_q + CNT_W'(1);
            if (PARITY_EN == 0 && cnt_q == CNT_LAST) begin
               complete = 1'b1;
               word     = shift_val;
            end
         end else begin
            // Parity bit: checked against the stored data, never shifted in.
            complete = 1'b1;
            word     = shreg_q;
            perr_hit = (^shreg_q) ^ ser_in;
         end
         if (complete) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Output holding register and sticky flags
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      perr_d  = perr_q;

      if (clr_flags) begin
         ovr_d  = 1'b0;
         perr_d = 1'b0;
      end

      if (complete) begin
         if (!valid_q || dout_ready) begin
            dout_d  = word;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
         // A dropped word still reports its parity status.
         if (perr_hit && PARITY_EN != 0) begin
            perr_d = 1'b1;
         end
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         dir_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         dir_q   <= dir_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         perr_q  <= perr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = (state_q == ST_SHIFT);
   assign overrun    = ovr_q;
   assign parity_err = perr_q;

endmodule

// File: tb/tb_shift_deser_rx.sv
// Directed testbench for shift_deser_rx. Two instances share the stimulus:
// u_dut without parity and u_par with PARITY_EN=1.
module tb_shift_deser_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, dir, ser_en, ser_in, dout_ready, clr_flags;
   logic [3:0] dout, p_dout;
   logic       dout_valid, busy, overrun, parity_err;
   logic       p_valid, p_busy, p_overrun, p_perr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shift_deser_rx #(.WIDTH(4), .PARITY_EN(0)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dir        (dir),
      .ser_en     (ser_en),
      .ser_in     (ser_in),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .overrun    (overrun),
      .parity_err (parity_err),
      .clr_flags  (clr_flags)
   );

   shift_deser_rx #(.WIDTH(4), .PARITY_EN(1)) u_par (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dir        (dir),
      .ser_en     (ser_en),
      .ser_in     (ser_in),
      .dout       (p_dout),
      .dout_valid (p_valid),
      .dout_ready (dout_ready),
      .busy       (p_busy),
      .overrun    (p_overrun),
      .parity_err (p_perr),
      .clr_flags  (clr_flags)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic d);
      dir   = d;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      repeat (gap) tick();
      ser_in = b;
      ser_en = 1'b1;
      tick();
      ser_en = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w, input logic d);
      do_start(d);
      for (int i = 3; i >= 0; i--) send_bit(w[i], 0);
   endtask

   task automatic consume();
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   int gaps [5] = '{3, 0, 7, 1, 5};
   logic [4:0] frame;

   initial begin
      rst = 1'b0; start = 1'b0; dir = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
      dout_ready = 1'b0; clr_flags = 1'b0;
      repeat (3) tick();
      chk("rst_dout", {4'h0, dout}, 8'h00);
      chk("rst_valid", {7'h0, dout_valid}, 8'h00);
      chk("rst_busy", {7'h0, busy}, 8'h00);
      chk("rst_ovr", {7'h0, overrun}, 8'h00);
      chk("rst_perr", {7'h0, p_perr}, 8'h00);
      rst = 1'b1;
      repeat (2) tick();

      // MSB-first 1,0,1,1
      do_start(1'b0);
      chk("msb_busy", {7'h0, busy}, 8'h01);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      chk("msb_valid_early", {7'h0, dout_valid}, 8'h00);
      send_bit(1'b1, 0);
      chk("msb_dout", {4'h0, dout}, 8'h0b);
      chk("msb_valid", {7'h0, dout_valid}, 8'h01);
      chk("msb_busy_done", {7'h0, busy}, 8'h00);
      consume();
      chk("msb_consumed", {7'h0, dout_valid}, 8'h00);
      chk("msb_dout_hold", {4'h0, dout}, 8'h0b);

      // LSB-first 1,0,1,1 then hold without ready
      do_start(1'b1);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
      chk("lsb_dout", {4'h0, dout}, 8'h0d);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("lsb_hold_dout", {4'h0, dout}, 8'h0d);
         chk("lsb_hold_valid", {7'h0, dout_valid}, 8'h01);
      end
      consume();
      chk("lsb_consumed", {7'h0, dout_valid}, 8'h00);

      // Overrun: A unconsumed, B dropped
      send_word(4'hA, 1'b0);
      chk("ovr_a", {4'h0, dout}, 8'h0a);
      send_word(4'h5, 1'b0);
      chk("ovr_keep_a", {4'h0, dout}, 8'h0a);
      chk("ovr_valid", {7'h0, dout_valid}, 8'h01);
      chk("ovr_flag", {7'h0, overrun}, 8'h01);
      tick();
      chk("ovr_sticky", {7'h0, overrun}, 8'h01);
      pulse_clr();
      chk("ovr_clr", {7'h0, overrun}, 8'h00);

      // B completes with ready high on its completion edge
      do_start(1'b0);
      send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      chk("rdy_still_a", {4'h0, dout}, 8'h0a);
      dout_ready = 1'b1;
      send_bit(1'b1, 0);
      dout_ready = 1'b0;
      chk("rdy_dout_b", {4'h0, dout}, 8'h05);
      chk("rdy_valid", {7'h0, dout_valid}, 8'h01);
      chk("rdy_no_ovr", {7'h0, overrun}, 8'h00);
      pulse_clr();
      chk("rdy_clr_ovr", {7'h0, overrun}, 8'h00);
      consume();

      // Restart mid-frame
      do_start(1'b0);
      send_bit(1'b1, 0); send_bit(1'b1, 0);
      chk("abort_no_word", {7'h0, dout_valid}, 8'h00);
      do_start(1'b0);
      chk("abort_busy", {7'h0, busy}, 8'h01);
      send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      chk("abort_partial", {7'h0, dout_valid}, 8'h00);
      send_bit(1'b0, 0);
      chk("abort_dout", {4'h0, dout}, 8'h02);
      chk("abort_valid", {7'h0, dout_valid}, 8'h01);
      chk("abort_no_ovr", {7'h0, overrun}, 8'h00);
      consume();
      repeat (3) tick();
      chk("abort_no_extra", {7'h0, dout_valid}, 8'h00);

      // Asynchronous reset mid-frame
      send_word(4'h9, 1'b0);
      do_start(1'b0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      rst = 1'b0;
      #1;
      chk("mrst_dout", {4'h0, dout}, 8'h00);
      chk("mrst_valid", {7'h0, dout_valid}, 8'h00);
      chk("mrst_busy", {7'h0, busy}, 8'h00);
      tick();
      rst = 1'b1;
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      chk("mrst_no_word", {7'h0, dout_valid}, 8'h00);
      chk("mrst_idle", {7'h0, busy}, 8'h00);
      send_word(4'hC, 1'b0);
      chk("mrst_dout_c", {4'h0, dout}, 8'h0c);
      chk("mrst_valid_c", {7'h0, dout_valid}, 8'h01);

      // Parity instance
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      do_start(1'b0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
      chk("par_wait_valid", {7'h0, p_valid}, 8'h00);
      chk("par_wait_busy", {7'h0, p_busy}, 8'h01);
      send_bit(1'b1, 0);
      chk("par_ok_dout", {4'h0, p_dout}, 8'h0b);
      chk("par_ok_valid", {7'h0, p_valid}, 8'h01);
      chk("par_ok_err", {7'h0, p_perr}, 8'h00);
      consume();
      do_start(1'b0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      chk("par_bad_dout", {4'h0, p_dout}, 8'h0b);
      chk("par_bad_err", {7'h0, p_perr}, 8'h01);
      consume();
      pulse_clr();
      chk("par_clr", {7'h0, p_perr}, 8'h00);

      // Same two frames with idle gaps between strobes
      for (int f = 0; f < 2; f++) begin
         frame = (f == 0) ? 5'b10111 : 5'b10110;
         do_start(1'b0);
         for (int i = 4; i >= 0; i--) send_bit(frame[i], gaps[i]);
         chk("gap_dout", {4'h0, p_dout}, 8'h0b);
         chk("gap_valid", {7'h0, p_valid}, 8'h01);
         chk("gap_err", {7'h0, p_perr}, (f == 0) ? 8'h00 : 8'h01);
         consume();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_deser_rx.md
Name: shift_deser_rx

Overview:
- Receive-side counterpart of the universal shift register: deserialises a framed serial bit stream back into parallel words.
- Accepts one bit per strobe, MSB-first (shift-left fill) or LSB-first (shift-right fill), with optional even-parity check.
- Presents each word on a valid/ready output holding register.
- Sits between a serial source (shift register sr/sl output or external pin) and a parallel consumer or debug probe.

Parameters:
WIDTH, 4, data word width in bits (>=2)
PARITY_EN, 0, 1 = one even-parity bit follows the data bits in each frame
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  frame-start pulse; the bit after it is the first frame bit
dir  input  1  0 = MSB first, 1 = LSB first; sampled only on an accepted start
ser_en  input  1  bit strobe; ser_in is captured when high in SHIFT
ser_in  input  1  serial data bit
dout  output  WIDTH  last completed word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
busy  output  1  high while in SHIFT
overrun  output  1  sticky: completed word dropped because dout was still full
parity_err  output  1  sticky: parity mismatch on a completed frame (0 if PARITY_EN=0)
clr_flags  input  1  synchronous clear of overrun and parity_err

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, any time, including mid-frame): state=IDLE, shift reg=0, counter=0, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0. Partial frame discarded. No word emitted after reset release until a new start.
- FSM states:
  - IDLE: start=1 -> SHIFT, counter=0, shreg=0, dir latched. ser_en ignored in IDLE and on the start cycle itself.
  - SHIFT: each edge with ser_en=1 captures one bit and increments counter.
    - dir=0: shreg <= {shreg[WIDTH-2:0], ser_in}.
    - dir=1: shreg <= {ser_in, shreg[WIDTH-1:1]}.
    - Once WIDTH data bits are captured and PARITY_EN=1, the next strobed bit is the parity bit. It is not shifted in.
- Completion: the edge capturing the final frame bit (data or parity) performs completion in the same cycle and the FSM returns to IDLE.
  - Assembled word = the next-state shreg value.
  - Latency: dout/dout_valid update on that edge, so they are visible the cycle after the last ser_en.
- start while in SHIFT: abort the current frame without emitting, restart at counter=0, re-latch dir. No flag.
- Output register:
  - If dout_valid=0, or dout_valid=1 & dout_ready=1 on the completion edge: load dout, dout_valid=1, no overrun.
  - If dout_valid=1 & dout_ready=0 on the completion edge: keep old dout, drop the new word, set overrun=1.
  - Consumption without completion: dout_valid=1 & dout_ready=1 -> dout_valid=0. dout holds its value.
  - dout stable while dout_valid=1 and not accepted.
- Parity (PARITY_EN=1):
  - Mismatch: XOR of data bits XOR parity bit = 1. The word is still delivered and parity_err is set.
  - A dropped word (overrun) still updates parity_err.
- Flags:
  - Set has priority over clr_flags in the same cycle.
  - busy = (state==SHIFT), registered.
- ser_en gaps of any length inside a frame are legal. There is no timeout.

Test Plan:
- Reset, then WIDTH=4, dir=0, start, ser_en with bits 1,0,1,1 -> dout=4'b1011, dout_valid rises the cycle after the 4th strobe, busy=0 same cycle.
- Same bits with dir=1 -> dout=4'b1101. Hold dout_ready=0 for 5 cycles -> dout/dout_valid stable; pulse dout_ready -> dout_valid=0 next cycle.
- Frame A=4'hA left unconsumed, frame B=4'h5 completes with dout_ready=0 -> dout stays 4'hA, overrun=1. Repeat with dout_ready=1 on B's completion edge -> dout=4'h5, dout_valid=1, overrun stays 0. Then clr_flags -> overrun=0.
- Start after 2 bits (1,1), then 0,0,1,0 MSB-first -> single word 4'b0010, no extra word. Assert rst mid-frame after 3 bits -> all outputs 0; post-reset frame 4'hC received correctly.
- PARITY_EN=1: data 1,0,1,1 + parity 1 -> dout=4'hB, parity_err=0. Data 1,0,1,1 + parity 0 -> dout=4'hB, parity_err=1. ser_en gaps of 0-7 idle cycles between bits -> same results.
